// File: rtl/camera_ray_gen.sv
`default_nettype none
// ============================================================================
// camera_ray_gen : pinhole primary-ray generator, raster order, add-only stepping
// Rev 1.0
// ============================================================================
module camera_ray_gen #(
    parameter int D_BITS = 32,
    parameter int Q_BITS = 10,
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64,
    parameter int X_BITS = $clog2(WIDTH),
    parameter int Y_BITS = $clog2(HEIGHT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [3*D_BITS-1:0]   cam_origin,
    input  logic [D_BITS-1:0]     pixel_pitch,
    input  logic [D_BITS-1:0]     focal,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [6*D_BITS-1:0]   ray_out,
    output logic [X_BITS-1:0]     pixel_x,
    output logic [Y_BITS-1:0]     pixel_y,
    output logic                  busy,
    output logic                  done
);

    localparam int              C_X_SHIFT = $clog2(WIDTH / 2);
    localparam int              C_Y_SHIFT = $clog2(HEIGHT / 2);
    localparam logic [X_BITS-1:0] C_X_LAST = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0] C_Y_LAST = Y_BITS'(HEIGHT - 1);

    generate
        if ((WIDTH < 2) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
            $error("camera_ray_gen: WIDTH must be a power of two >= 2");
        end
        if ((HEIGHT < 2) || ((HEIGHT & (HEIGHT - 1)) != 0)) begin : g_bad_height
            $error("camera_ray_gen: HEIGHT must be a power of two >= 2");
        end
        if ((Q_BITS < 0) || (Q_BITS >= D_BITS)) begin : g_bad_q
            $error("camera_ray_gen: Q_BITS must lie in [0, D_BITS)");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [D_BITS-1:0]   r_org_x;
    logic [D_BITS-1:0]   r_org_y;
    logic [D_BITS-1:0]   r_org_z;
    logic [D_BITS-1:0]   r_pitch;
    logic [D_BITS-1:0]   r_focal;
    logic [D_BITS-1:0]   r_row_x0;
    logic [D_BITS-1:0]   r_dir_x;
    logic [D_BITS-1:0]   r_dir_y;
    logic [D_BITS-1:0]   r_dir_z;
    logic [X_BITS-1:0]   r_x;
    logic [Y_BITS-1:0]   r_y;
    logic                r_busy;
    logic                r_done;
    logic [D_BITS-1:0]   w_row_start;

    // Leftmost column offset; also reloaded into dir_x at every row wrap.
    assign w_row_start = -(r_pitch << C_X_SHIFT);

    assign out_wr_en = (r_state == S_RUN) && !out_full && !abort;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_org_x  <= '0;
            r_org_y  <= '0;
            r_org_z  <= '0;
            r_pitch  <= '0;
            r_focal  <= '0;
            r_row_x0 <= '0;
            r_dir_x  <= '0;
            r_dir_y  <= '0;
            r_dir_z  <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_org_x <= cam_origin[0*D_BITS +: D_BITS];
                        r_org_y <= cam_origin[1*D_BITS +: D_BITS];
                        r_org_z <= cam_origin[2*D_BITS +: D_BITS];
                        r_pitch <= pixel_pitch;
                        r_focal <= focal;
                        r_busy  <= 1'b1;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_dir_x  <= w_row_start;
                        r_row_x0 <= w_row_start;
                        r_dir_y  <= r_pitch << C_Y_SHIFT;
                        r_dir_z  <= r_focal;
                        r_x      <= '0;
                        r_y      <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (!out_full) begin
                        if (r_x != C_X_LAST) begin
                            r_x     <= r_x + X_BITS'(1);
                            r_dir_x <= r_dir_x + r_pitch;
                        end else if (r_y != C_Y_LAST) begin
                            r_x     <= '0;
                            r_y     <= r_y + Y_BITS'(1);
                            r_dir_x <= r_row_x0;
                            r_dir_y <= r_dir_y - r_pitch;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ray_out = {r_dir_z, r_dir_y, r_dir_x, r_org_z, r_org_y, r_org_x};
    assign pixel_x = r_x;
    assign pixel_y = r_y;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_camera_ray_gen.sv
`default_nettype none
// ============================================================================
// tb_camera_ray_gen : directed self-checking bench, 4x2 frame
// Rev 1.0
// ============================================================================
module tb_camera_ray_gen;

    localparam int D = 32;
    localparam int W = 4;
    localparam int H = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             out_full = 1'b0;
    logic [3*D-1:0]   cam_origin = '0;
    logic [D-1:0]     pixel_pitch = '0;
    logic [D-1:0]     focal = '0;
    logic             out_wr_en;
    logic [6*D-1:0]   ray_out;
    logic [1:0]       pixel_x;
    logic [0:0]       pixel_y;
    logic             busy;
    logic             done;

    int tests = 0;
    int fails = 0;

    camera_ray_gen #(
        .D_BITS (D),
        .Q_BITS (10),
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .cam_origin  (cam_origin),
        .pixel_pitch (pixel_pitch),
        .focal       (focal),
        .out_full    (out_full),
        .out_wr_en   (out_wr_en),
        .ray_out     (ray_out),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected ray for pixel (x,y) with WIDTH=4, HEIGHT=2: dir_x = x*p - 2p, dir_y = p - y*p.
    function automatic logic [6*D-1:0] exp_ray(input logic [3*D-1:0] org, input logic [D-1:0] p,
                                               input logic [D-1:0] f, input int x, input int y);
        logic [D-1:0] dx;
        logic [D-1:0] dy;
        dx = (p * D'(x)) - (p << 1);
        dy = p - (p * D'(y));
        return {f, dy, dx, org};
    endfunction

    task automatic do_start(input logic [3*D-1:0] org, input logic [D-1:0] p, input logic [D-1:0] f);
        @(negedge clock);
        cam_origin = org;
        pixel_pitch = p;
        focal = f;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b1 || out_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL init_cycle: busy=%b wr=%b, expected busy=1 wr=0", busy, out_wr_en);
        end
    endtask

    task automatic test_full_frame(input logic [3*D-1:0] org, input logic [D-1:0] p,
                                   input logic [D-1:0] f, input string name);
        do_start(org, p, f);
        for (int i = 0; i < W * H; i++) begin
            @(negedge clock);
            #1;
            tests++;
            if ({out_wr_en, pixel_x, pixel_y, ray_out} !==
                {1'b1, 2'(i % W), 1'(i / W), exp_ray(org, p, f, i % W, i / W)}) begin
                fails++;
                $display("FAIL %s pix%0d: wr=%b x=%0d y=%0d ray=%h, expected wr=1 x=%0d y=%0d ray=%h",
                         name, i, out_wr_en, pixel_x, pixel_y, ray_out, i % W, i / W,
                         exp_ray(org, p, f, i % W, i / W));
            end
        end
        @(negedge clock);
        #1;
        tests++;
        if ({done, busy, out_wr_en} !== 3'b100) begin
            fails++;
            $display("FAIL %s done_pulse: done=%b busy=%b wr=%b, expected 1 0 0", name, done, busy, out_wr_en);
        end
        @(negedge clock);
        #1;
        tests++;
        if ({done, busy, out_wr_en} !== 3'b000) begin
            fails++;
            $display("FAIL %s after_done: done=%b busy=%b wr=%b, expected 0 0 0", name, done, busy, out_wr_en);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clock);
        #1;
        tests++;
        if ({out_wr_en, busy, done, pixel_x, pixel_y, ray_out} !== '0) begin
            fails++;
            $display("FAIL reset_state: wr=%b busy=%b done=%b x=%0d y=%0d ray=%h, expected all 0",
                     out_wr_en, busy, done, pixel_x, pixel_y, ray_out);
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        tests++;
        if ({out_wr_en, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL idle_after_reset: wr=%b busy=%b done=%b, expected 0 0 0", out_wr_en, busy, done);
        end
    endtask

    task automatic test_basic();
        // origin (0,0,-5120), pitch 1024, focal 1024: dir_x -2048,-1024,0,1024
        test_full_frame({32'hFFFF_EC00, 32'd0, 32'd0}, 32'd1024, 32'd1024, "basic");
    endtask

    task automatic test_backpressure();
        int idx;
        int writes;
        logic exp_wr;
        logic [3*D-1:0] org;
        org = {32'hFFFF_EC00, 32'd0, 32'd0};
        writes = 0;
        do_start(org, 32'd1024, 32'd1024);
        for (int cyc = 0; cyc < 11; cyc++) begin
            @(negedge clock);
            out_full = (cyc >= 2 && cyc < 5);
            #1;
            idx = (cyc < 2) ? cyc : ((cyc < 5) ? 2 : cyc - 3);
            exp_wr = !(cyc >= 2 && cyc < 5);
            if (out_wr_en === 1'b1) writes++;
            tests++;
            if ({out_wr_en, pixel_x, pixel_y, ray_out} !==
                {exp_wr, 2'(idx % W), 1'(idx / W), exp_ray(org, 32'd1024, 32'd1024, idx % W, idx / W)}) begin
                fails++;
                $display("FAIL backpressure cyc%0d: wr=%b x=%0d y=%0d ray=%h, expected wr=%b x=%0d y=%0d",
                         cyc, out_wr_en, pixel_x, pixel_y, ray_out, exp_wr, idx % W, idx / W);
            end
        end
        out_full = 1'b0;
        @(negedge clock);
        #1;
        tests++;
        if ({done, busy, out_wr_en} !== 3'b100) begin
            fails++;
            $display("FAIL backpressure done: done=%b busy=%b wr=%b, expected 1 0 0", done, busy, out_wr_en);
        end
        tests++;
        if (writes != 8) begin
            fails++;
            $display("FAIL backpressure count: writes=%0d, expected 8", writes);
        end
    endtask

    task automatic test_busy_start();
        logic [3*D-1:0] org;
        org = {32'd300, 32'd200, 32'd100};
        do_start(org, 32'd1024, 32'd2048);
        for (int i = 0; i < W * H; i++) begin
            @(negedge clock);
            start = (i == 3);
            pixel_pitch = 32'd512;
            #1;
            tests++;
            if ({out_wr_en, ray_out} !== {1'b1, exp_ray(org, 32'd1024, 32'd2048, i % W, i / W)}) begin
                fails++;
                $display("FAIL busy_start pix%0d: wr=%b ray=%h, expected wr=1 ray=%h",
                         i, out_wr_en, ray_out, exp_ray(org, 32'd1024, 32'd2048, i % W, i / W));
            end
        end
        @(negedge clock);
        start = 1'b1;
        #1;
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL busy_start done: done=%b, expected 1", done);
        end
        @(negedge clock);
        start = 1'b0;
        #1;
        tests++;
        if ({busy, out_wr_en, done} !== 3'b000) begin
            fails++;
            $display("FAIL start_in_done: busy=%b wr=%b done=%b, expected 0 0 0", busy, out_wr_en, done);
        end
        // pitch 512 now takes effect: first dir_x = -1024
        test_full_frame(org, 32'd512, 32'd2048, "pitch512");
    endtask

    task automatic test_abort();
        int writes;
        writes = 0;
        do_start({32'd7, 32'd8, 32'd9}, 32'd1024, 32'd1024);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            if (out_wr_en === 1'b1) writes++;
        end
        @(negedge clock);
        abort = 1'b1;
        #1;
        tests++;
        if ({out_wr_en, pixel_x, pixel_y} !== {1'b0, 2'd1, 1'd1}) begin
            fails++;
            $display("FAIL abort_cycle: wr=%b x=%0d y=%0d, expected wr=0 x=1 y=1", out_wr_en, pixel_x, pixel_y);
        end
        @(negedge clock);
        abort = 1'b0;
        #1;
        tests++;
        if ({busy, out_wr_en, done} !== 3'b000) begin
            fails++;
            $display("FAIL abort_idle: busy=%b wr=%b done=%b, expected 0 0 0", busy, out_wr_en, done);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            if (out_wr_en === 1'b1) writes++;
            tests++;
            if (done !== 1'b0) begin
                fails++;
                $display("FAIL abort_no_done: done=%b, expected 0", done);
            end
        end
        tests++;
        if (writes != 5) begin
            fails++;
            $display("FAIL abort_count: writes=%0d, expected 5", writes);
        end
        test_full_frame({32'd7, 32'd8, 32'd9}, 32'd1024, 32'd1024, "after_abort");
    endtask

    task automatic test_midframe_reset();
        do_start({32'd1, 32'd2, 32'd3}, 32'd1024, 32'd1024);
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({out_wr_en, busy, done, pixel_x, pixel_y, ray_out} !== '0) begin
            fails++;
            $display("FAIL async_reset: wr=%b busy=%b done=%b x=%0d y=%0d ray=%h, expected all 0",
                     out_wr_en, busy, done, pixel_x, pixel_y, ray_out);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            tests++;
            if ({out_wr_en, busy} !== 2'b00) begin
                fails++;
                $display("FAIL post_reset_idle: wr=%b busy=%b, expected 0 0", out_wr_en, busy);
            end
        end
        test_full_frame({32'd1, 32'd2, 32'd3}, 32'd1024, 32'd1024, "after_reset");
    endtask

    task automatic test_wrap();
        // pitch 0x7FFFFFFF: dir_x 0x2, 0x80000001, 0x0, 0x7FFFFFFF; dir_y 0x7FFFFFFF then 0
        test_full_frame({32'd0, 32'd0, 32'd0}, 32'h7FFF_FFFF, 32'd1024, "wrap");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_start();
        test_abort();
        test_midframe_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
